adder_sched: RTL and testbench

ADDER_SCHED -- requirements
Module: adder_sched

---
 rtl/adder_sched.sv | 139 +++++++++++++
 tb/tb_adder_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sched.sv
// rtl/adder_sched.sv - round-robin scheduler sharing one external adder among NREQ requesters
module adder_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int LAT   = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*WIDTH-1:0]   req_a_i,
  input  logic [NREQ*WIDTH-1:0]   req_b_i,
  output logic [NREQ-1:0]         req_ready_o,
  output logic [WIDTH-1:0]        add_a_o,
  output logic [WIDTH-1:0]        add_b_o,
  input  logic [WIDTH-1:0]        add_res_i,
  output logic [NREQ-1:0]         rsp_valid_o,
  output logic [WIDTH-1:0]        rsp_res_o,
  input  logic [NREQ-1:0]         rsp_ready_i,
  output logic                    busy_o,
  output logic [31:0]             done_cnt_o
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [GW-1:0]   r_last_grant;
  logic [GW-1:0]   r_owner;
  logic [GW-1:0]   w_grant;
  logic            w_grant_vld;
  logic [3:0]      r_cnt;
  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic [WIDTH-1:0] r_rsp_res;
  logic            r_busy;
  logic [31:0]     r_done_cnt;

  // Round-robin pick: first valid requester after the last one served, wrapping.
  always_comb begin
    int            w_idx;
    logic [GW-1:0] w_idx_b;
    w_grant     = r_last_grant;
    w_grant_vld = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      w_idx   = (int'(r_last_grant) + i) % NREQ;
      w_idx_b = GW'(w_idx);
      if (!w_grant_vld && req_valid_i[w_idx_b]) begin
        w_grant     = w_idx_b;
        w_grant_vld = 1'b1;
      end
    end
  end

  // Next-state and handshake decode; only IDLE may grant, only RESP presents a result.
  always_comb begin
    w_next      = r_state;
    req_ready_o = '0;
    rsp_valid_o = '0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_vld) begin
          req_ready_o[w_grant] = 1'b1;
          w_next               = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o[r_owner] = 1'b1;
        if (rsp_ready_i[r_owner]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register plus registered busy flag tracking the state being entered.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
    end
  end

  // Capture operands and owner on the grant edge; operands stay put until the next grant.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_add_a      <= '0;
      r_add_b      <= '0;
      r_owner      <= '0;
      r_last_grant <= GW'(NREQ - 1);
    end else if (r_state == S_IDLE && w_grant_vld) begin
      r_add_a      <= req_a_i[w_grant*WIDTH +: WIDTH];
      r_add_b      <= req_b_i[w_grant*WIDTH +: WIDTH];
      r_owner      <= w_grant;
      r_last_grant <= w_grant;
    end
  end

  // Latency countdown; the adder output is sampled on the edge where the count reaches one.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_cnt     <= '0;
      r_rsp_res <= '0;
    end else begin
      if (r_state == S_IDLE && w_grant_vld) begin
        r_cnt <= 4'(LAT);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) r_rsp_res <= add_res_i;
      end
    end
  end

  // Completed-operation counter, bumped when the owner accepts the response.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_done_cnt <= '0;
    end else if (r_state == S_RESP && rsp_ready_i[r_owner]) begin
      r_done_cnt <= r_done_cnt + 32'd1;
    end
  end

  assign add_a_o    = r_add_a;
  assign add_b_o    = r_add_b;
  assign rsp_res_o  = r_rsp_res;
  assign busy_o     = r_busy;
  assign done_cnt_o = r_done_cnt;

endmodule

// File: tb/tb_adder_sched.sv
// tb/tb_adder_sched.sv - randomized scoreboard bench for adder_sched
module tb_adder_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int LAT   = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic [WIDTH-1:0]      add_res;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_res;
  logic [NREQ-1:0]       rsp_ready;
  logic                  busy;
  logic [31:0]           done_cnt;

  int total = 0;
  int bad   = 0;

  adder_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) u_dut (
    .clk_i       (clk),
    .reset_i     (rst_n),
    .req_valid_i (req_valid),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_ready_o (req_ready),
    .add_a_o     (add_a),
    .add_b_o     (add_b),
    .add_res_i   (add_res),
    .rsp_valid_o (rsp_valid),
    .rsp_res_o   (rsp_res),
    .rsp_ready_i (rsp_ready),
    .busy_o      (busy),
    .done_cnt_o  (done_cnt)
  );

  always #5 clk = ~clk;

  // External adder: sum appears LAT-1 register stages after the operand registers.
  logic [WIDTH-1:0] pipe [0:LAT-2];
  always @(posedge clk) begin
    pipe[0] <= add_a + add_b;
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign add_res = pipe[LAT-2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int owner;
    int a;
    int b;
    int sum;
    int gcyc;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: arbitration and handshake timing derived from the rules, pushes expectations.
  int m_cyc   = 0;
  bit m_busy  = 0;
  int m_owner = 0;
  int m_last  = NREQ - 1;
  int m_wait  = 0;
  int m_done  = 0;
  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] e_ready;
    logic [NREQ-1:0] e_rv;
    exp_t e;
    m_cyc++;
    if (!rst_n) begin
      m_busy = 0; m_last = NREQ - 1; m_wait = 0; m_done = 0; m_owner = 0;
      sb_q.delete();
    end else begin
      g = -1;
      if (!m_busy)
        for (int i = 1; i <= NREQ; i++)
          if (g < 0 && req_valid[(m_last + i) % NREQ]) g = (m_last + i) % NREQ;
      e_ready = '0;
      if (g >= 0) e_ready[g] = 1'b1;
      e_rv = '0;
      if (m_busy && m_wait >= LAT) e_rv[m_owner] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("done_cnt", done_cnt, m_done);
      if (g >= 0) begin
        e.owner = g;
        e.a     = int'(req_a[g*WIDTH +: WIDTH]);
        e.b     = int'(req_b[g*WIDTH +: WIDTH]);
        e.sum   = (e.a + e.b) % (1 << WIDTH);
        e.gcyc  = m_cyc;
        sb_q.push_back(e);
        m_busy = 1; m_owner = g; m_last = g; m_wait = 0;
      end else if (m_busy) begin
        if (m_wait >= LAT && rsp_ready[m_owner]) begin
          m_busy = 0;
          m_done++;
        end else begin
          m_wait++;
        end
      end
    end
  end

  // Monitor: whenever a response is presented, compare it with the oldest expectation.
  int  mon_cyc = 0;
  bit  seen    = 0;
  always @(negedge clk) begin
    exp_t e;
    mon_cyc++;
    if (!rst_n) begin
      seen = 0;
    end else if (rsp_valid != '0) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb_q[0];
        chk("rsp_owner", 32'(rsp_valid), 32'(1) << e.owner);
        chk("rsp_res", 32'(rsp_res), 32'(e.sum));
        chk("add_a_hold", 32'(add_a), 32'(e.a));
        chk("add_b_hold", 32'(add_b), 32'(e.b));
        if (!seen) chk("latency", 32'(mon_cyc - e.gcyc), 32'(LAT + 1));
        seen = 1;
        if ((rsp_valid & rsp_ready) != '0) begin
          void'(sb_q.pop_front());
          seen = 0;
        end
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_add_a", 32'(add_a), 32'd0);
    chk("rst_add_b", 32'(add_b), 32'd0);
    chk("rst_rsp_res", 32'(rsp_res), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_cnt", done_cnt, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
  endtask

  task automatic issue(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    n = 0;
    @(posedge clk); #1;
    req_valid[k] = 1'b1;
    req_a[k*WIDTH +: WIDTH] = a;
    req_b[k*WIDTH +: WIDTH] = b;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[k] && n < 100);
    if (!req_ready[k]) chk("grant_timeout", 32'(req_ready[k]), 32'd1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || rsp_valid != '0) && n < 200);
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int grants;
    int n;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single operation and overflow cases with an always-ready consumer.
    rsp_ready = '1;
    issue(2, 8'h12, 8'h34);
    wait_idle();
    issue(0, 8'hFF, 8'h02);
    wait_idle();
    issue(3, 8'h80, 8'h80);
    wait_idle();

    // All requesters asserting: five grants rotate through every index.
    @(posedge clk); #1;
    for (int k = 0; k < NREQ; k++) begin
      req_a[k*WIDTH +: WIDTH] = 8'(8'h10 * (k + 1));
      req_b[k*WIDTH +: WIDTH] = 8'(8'h03 + k);
    end
    req_valid = '1;
    grants = 0;
    n = 0;
    while (grants < 5 && n < 200) begin
      @(negedge clk);
      n++;
      if (req_ready != '0) grants++;
    end
    if (grants < 5) chk("rr_timeout", 32'(grants), 32'd5);
    @(posedge clk); #1 req_valid = '0;
    wait_idle();

    // Stalled response: owner holds ready low while non-owners assert theirs and others request.
    rsp_ready = 4'b1101;
    issue(1, 8'hA5, 8'h3C);
    req_valid = 4'b1101;
    repeat (LAT + 12) @(posedge clk);
    #1 rsp_ready = '1;
    @(posedge clk); #1 req_valid = '0;
    wait_idle();

    // Reset while waiting on the adder.
    issue(3, 8'h21, 8'h43);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    req_valid = 4'b1010;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 50);
    chk("post_reset_grant", 32'(req_ready), 32'h2);
    @(posedge clk); #1 req_valid = '0;
    wait_idle();

    // Random traffic: valids, operands and response readiness change every cycle.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      req_valid = NREQ'($urandom);
      req_a     = ($urandom << 16) ^ $urandom;
      req_b     = ($urandom << 16) ^ $urandom;
      rsp_ready = NREQ'($urandom);
    end

    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = '1;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("drain_queue", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
